// File: rtl/myproject_sdiv_pkg.sv
// Shared widths, state encoding, saturation constants and result payload
// for the 36s/12s -> 24s sequential signed divider.
package myproject_sdiv_pkg;

  localparam int unsigned DIN0_W = 36;
  localparam int unsigned DIN1_W = 12;
  localparam int unsigned DOUT_W = 24;
  localparam int unsigned PREM_W = DIN1_W + 1;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef struct packed {
    logic [DOUT_W-1:0] quot;
    logic [DIN1_W-1:0] rem;
    logic              ovf;
    logic              dbz;
  } sdiv_res_t;

endpackage

// File: rtl/myproject_sdiv_36s_12s_24_seq_if.sv
// Block-level handshake plus operand/result bus for the sequential divider.
interface myproject_sdiv_36s_12s_24_seq_if;
  import myproject_sdiv_pkg::*;

  logic              ap_start;
  logic              ap_ready;
  logic              ap_idle;
  logic              ap_done;
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic [DOUT_W-1:0] quot;
  logic [DIN1_W-1:0] rem;
  logic              ovf;
  logic              dbz;

  modport master (
    output ap_start, din0, din1,
    input  ap_ready, ap_idle, ap_done, quot, rem, ovf, dbz
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_ready, ap_idle, ap_done, quot, rem, ovf, dbz
  );

endinterface

// File: rtl/myproject_sdiv_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep the difference when it does not go negative.
module myproject_sdiv_step
  import myproject_sdiv_pkg::*;
(
  input  logic [PREM_W-1:0] prem_i,
  input  logic              bit_i,
  input  logic [DIN1_W-1:0] dsr_i,
  output logic [PREM_W-1:0] prem_o,
  output logic              qbit_o
);

  localparam int unsigned SHW = PREM_W + 1;

  logic [SHW-1:0] shifted;

  always_comb begin
    shifted = {prem_i, bit_i};
    qbit_o  = (shifted >= SHW'(dsr_i));
    prem_o  = qbit_o ? PREM_W'(shifted - SHW'(dsr_i)) : PREM_W'(shifted);
  end

endmodule

// File: rtl/myproject_sdiv_36s_12s_24_seq.sv
// Sequential signed divider, 36s / 12s -> 24s quotient + 12s remainder.
// Build option MYPROJECT_SDIV_SAT_EN: saturate overflowing quotients instead of wrapping.
module myproject_sdiv_36s_12s_24_seq
  import myproject_sdiv_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst,
  myproject_sdiv_36s_12s_24_seq_if.slave bus
);

  state_e            state_q, state_d;
  logic [DIN0_W-1:0] dvd_q, dvd_d;
  logic [DIN0_W-1:0] quo_q, quo_d;
  logic [PREM_W-1:0] prem_q, prem_d;
  logic [DIN1_W-1:0] dsr_q, dsr_d;
  logic              sgn0_q, sgn0_d;
  logic              sgn1_q, sgn1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  sdiv_res_t         res_q, res_d;
  logic              done_q, done_d;
  logic              idle_q, idle_d;

  logic [PREM_W-1:0] step_prem;
  logic              step_qbit;
  logic              capture_c;
  logic              neg_c, dbz_c, ovf_c;
  logic [DOUT_W-1:0] qwrap_c;
  logic [DIN1_W-1:0] rmag_c;
  sdiv_res_t         fix_c;

  myproject_sdiv_step u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[DIN0_W-1]),
    .dsr_i  (dsr_q),
    .prem_o (step_prem),
    .qbit_o (step_qbit)
  );

  // Sign/range fix-up of the unsigned quotient and remainder magnitudes.
  always_comb begin
    neg_c   = sgn0_q ^ sgn1_q;
    dbz_c   = (dsr_q == '0);
    ovf_c   = neg_c ? (quo_q > DIN0_W'(QMIN)) : (quo_q > DIN0_W'(QMAX));
    qwrap_c = neg_c ? DOUT_W'(-quo_q) : DOUT_W'(quo_q);
    rmag_c  = prem_q[DIN1_W-1:0];
    fix_c   = '0;
    if (dbz_c) begin
      fix_c.quot = sgn0_q ? QMIN : QMAX;
      fix_c.dbz  = 1'b1;
    end else begin
`ifdef MYPROJECT_SDIV_SAT_EN
      fix_c.quot = ovf_c ? (neg_c ? QMIN : QMAX) : qwrap_c;
`else
      fix_c.quot = qwrap_c;
`endif
      fix_c.rem  = sgn0_q ? DIN1_W'(-rmag_c) : rmag_c;
      fix_c.ovf  = ovf_c;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    quo_d     = quo_q;
    prem_d    = prem_q;
    dsr_d     = dsr_q;
    sgn0_d    = sgn0_q;
    sgn1_d    = sgn1_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    capture_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          capture_c = 1'b1;
          sgn0_d    = bus.din0[DIN0_W-1];
          sgn1_d    = bus.din1[DIN1_W-1];
          dvd_d     = bus.din0[DIN0_W-1] ? DIN0_W'(-bus.din0) : bus.din0;
          dsr_d     = bus.din1[DIN1_W-1] ? DIN1_W'(-bus.din1) : bus.din1;
          quo_d     = '0;
          prem_d    = '0;
          cnt_d     = CNT_W'(DIN0_W - 1);
          state_d   = CALC;
        end
      end
      CALC: begin
        dvd_d  = {dvd_q[DIN0_W-2:0], 1'b0};
        quo_d  = {quo_q[DIN0_W-2:0], step_qbit};
        prem_d = step_prem;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        res_d   = fix_c;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    idle_d = (state_d == IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      prem_q  <= '0;
      dsr_q   <= '0;
      sgn0_q  <= 1'b0;
      sgn1_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      prem_q  <= prem_d;
      dsr_q   <= dsr_d;
      sgn0_q  <= sgn0_d;
      sgn1_q  <= sgn1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
    end
  end

  // ap_ready acknowledges the capture in the same cycle ap_start is sampled.
  assign bus.ap_ready = capture_c & ~ap_rst;
  assign bus.ap_idle  = idle_q;
  assign bus.ap_done  = done_q;
  assign bus.quot     = res_q.quot;
  assign bus.rem      = res_q.rem;
  assign bus.ovf      = res_q.ovf;
  assign bus.dbz      = res_q.dbz;

endmodule

// File: tb/tb_myproject_sdiv_36s_12s_24_seq.sv
// Scoreboard bench for the sequential signed divider: the driver queues
// hand-computed results, a negedge monitor checks them on every ap_done.
module tb_myproject_sdiv_36s_12s_24_seq;

  typedef struct {
    logic [23:0] q;
    logic [11:0] r;
    logic        o;
    logic        z;
    string       name;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst;

  myproject_sdiv_36s_12s_24_seq_if bus ();

  myproject_sdiv_36s_12s_24_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  exp_t exp_q[$];
  int   rdy_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   prev_rdy = -1;
  bit   b2b = 1'b0;

`ifdef MYPROJECT_SDIV_SAT_EN
  localparam logic [23:0] Q_2P30   = 24'h7FFFFF;
  localparam logic [23:0] Q_M35M1  = 24'h7FFFFF;
  localparam logic [23:0] Q_2P23   = 24'h7FFFFF;
  localparam logic [23:0] Q_M2P23M = 24'h800000;
  localparam logic [23:0] Q_M35P1  = 24'h800000;
`else
  localparam logic [23:0] Q_2P30   = 24'h000000;
  localparam logic [23:0] Q_M35M1  = 24'h000000;
  localparam logic [23:0] Q_2P23   = 24'h800000;
  localparam logic [23:0] Q_M2P23M = 24'h7FFFFF;
  localparam logic [23:0] Q_M35P1  = 24'h000000;
`endif

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: latency, back-to-back spacing and result scoreboard.
  always @(negedge ap_clk) begin
    exp_t e;
    if (!ap_rst) begin
      if (bus.ap_ready) begin
        if (b2b && prev_rdy >= 0) chk("b2b_spacing", 64'(cyc - prev_rdy), 64'(39));
        prev_rdy = cyc;
        rdy_q.push_back(cyc);
      end
      if (bus.ap_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(bus.ap_done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk({e.name, ".quot"}, 64'(bus.quot), 64'(e.q));
          chk({e.name, ".rem"},  64'(bus.rem),  64'(e.r));
          chk({e.name, ".ovf"},  64'(bus.ovf),  64'(e.o));
          chk({e.name, ".dbz"},  64'(bus.dbz),  64'(e.z));
          chk({e.name, ".idle"}, 64'(bus.ap_idle), 64'(0));
          if (rdy_q.size() > 0) chk({e.name, ".latency"}, 64'(cyc - rdy_q.pop_front()), 64'(38));
          else                  chk({e.name, ".no_ready"}, 64'(rdy_q.size()), 64'(1));
        end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.ap_idle && n < 200) begin
      tick();
      n++;
    end
    if (!bus.ap_idle) chk("idle_timeout", 64'(bus.ap_idle), 64'(1));
  endtask

  task automatic push_exp(input logic [23:0] q, input logic [11:0] r,
                          input logic o, input logic z, input string nm);
    exp_t e;
    e.q = q; e.r = r; e.o = o; e.z = z; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Single operation; operands are scrambled during CALC to show they are ignored.
  task automatic issue(input logic [35:0] a, input logic [11:0] b, input logic [23:0] q,
                       input logic [11:0] r, input logic o, input logic z, input string nm);
    wait_idle();
    bus.din0     = a;
    bus.din1     = b;
    bus.ap_start = 1'b1;
    push_exp(q, r, o, z, nm);
    tick();
    bus.ap_start = 1'b0;
    repeat (38) begin
      bus.din0 = 36'({$urandom(), $urandom()});
      bus.din1 = 12'($urandom());
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [35:0] va[3];
    logic [11:0] vb[3];
    logic [23:0] vq[3];
    logic [11:0] vr[3];

    // Reset with ap_start high: reset must win.
    ap_rst       = 1'b1;
    bus.ap_start = 1'b1;
    bus.din0     = 36'd5;
    bus.din1     = 12'd1;
    repeat (3) tick();
    chk("rst.ready", 64'(bus.ap_ready), 64'(0));
    ap_rst       = 1'b0;
    bus.ap_start = 1'b0;
    chk("rst.idle", 64'(bus.ap_idle), 64'(1));
    chk("rst.done", 64'(bus.ap_done), 64'(0));
    chk("rst.quot", 64'(bus.quot), 64'(0));
    chk("rst.rem",  64'(bus.rem),  64'(0));
    chk("rst.ovf",  64'(bus.ovf),  64'(0));
    chk("rst.dbz",  64'(bus.dbz),  64'(0));

    issue(36'd1000,        12'd7,        24'd142,        12'd6,        1'b0, 1'b0, "p_div_p");
    issue(36'(-1000),      12'd7,        24'(-142),      12'(-6),      1'b0, 1'b0, "n_div_p");
    issue(36'd1000,        12'(-7),      24'(-142),      12'd6,        1'b0, 1'b0, "p_div_n");
    issue(36'(-1000),      12'(-7),      24'd142,        12'(-6),      1'b0, 1'b0, "n_div_n");
    issue(36'd123456789,   12'(-2000),   24'(-61728),    12'd789,      1'b0, 1'b0, "big_div_n");
    issue(36'd100000,      12'h800,      24'(-48),       12'd1696,     1'b0, 1'b0, "div_min12");
    issue(36'd8388607,     12'd1,        24'h7FFFFF,     12'd0,        1'b0, 1'b0, "qmax_fit");
    issue(36'(-8388608),   12'd1,        24'h800000,     12'd0,        1'b0, 1'b0, "qmin_fit");
    issue(36'd8388608,     12'd1,        Q_2P23,         12'd0,        1'b1, 1'b0, "qmax_ovf");
    issue(36'(-8388609),   12'd1,        Q_M2P23M,       12'd0,        1'b1, 1'b0, "qmin_ovf");
    issue(36'h040000000,   12'd1,        Q_2P30,         12'd0,        1'b1, 1'b0, "two30_div1");
    issue(36'h800000000,   12'hFFF,      Q_M35M1,        12'd0,        1'b1, 1'b0, "min36_div_m1");
    issue(36'h800000000,   12'd1,        Q_M35P1,        12'd0,        1'b1, 1'b0, "min36_div_1");
    issue(36'd5,           12'd0,        24'h7FFFFF,     12'd0,        1'b0, 1'b1, "p_div0");
    issue(36'(-5),         12'd0,        24'h800000,     12'd0,        1'b0, 1'b1, "n_div0");

    // ap_start held high: captures 39 cycles apart, junk operands between captures.
    va[0] = 36'd777;      vb[0] = 12'(-5); vq[0] = 24'(-155);  vr[0] = 12'd2;
    va[1] = 36'(-123456); vb[1] = 12'd100; vq[1] = 24'(-1234); vr[1] = 12'(-56);
    va[2] = 36'd1000;     vb[2] = 12'd7;   vq[2] = 24'd142;    vr[2] = 12'd6;
    wait_idle();
    prev_rdy     = -1;
    b2b          = 1'b1;
    bus.ap_start = 1'b1;
    k = 0;
    n = 0;
    while (k < 3 && n < 300) begin
      if (bus.ap_idle) begin
        bus.din0 = va[k];
        bus.din1 = vb[k];
        push_exp(vq[k], vr[k], 1'b0, 1'b0, $sformatf("b2b%0d", k));
        k++;
      end else begin
        bus.din0 = 36'({$urandom(), $urandom()});
        bus.din1 = 12'($urandom());
      end
      tick();
      n++;
    end
    bus.ap_start = 1'b0;
    if (k < 3) chk("b2b_timeout", 64'(k), 64'(3));
    repeat (40) tick();
    b2b = 1'b0;

    // Reset in the middle of CALC discards the operation.
    wait_idle();
    bus.din0     = 36'd1000;
    bus.din1     = 12'd7;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    repeat (19) tick();
    ap_rst = 1'b1;
    exp_q.delete();
    rdy_q.delete();
    tick();
    ap_rst = 1'b0;
    chk("midrst.idle", 64'(bus.ap_idle), 64'(1));
    chk("midrst.done", 64'(bus.ap_done), 64'(0));
    chk("midrst.quot", 64'(bus.quot), 64'(0));
    chk("midrst.rem",  64'(bus.rem),  64'(0));
    chk("midrst.ovf",  64'(bus.ovf),  64'(0));
    chk("midrst.dbz",  64'(bus.dbz),  64'(0));
    repeat (45) tick();
    issue(36'd1000, 12'd7, 24'd142, 12'd6, 1'b0, 1'b0, "after_rst");

    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) chk("drain", 64'(exp_q.size()), 64'(0));
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
